// File: rtl/spi_arb_pkg.sv
// Shared definitions for the SPI engine arbiter: FSM encoding, engine
// control/status bit positions and the byte-count to read-mask helper.
package spi_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_BUSY = 2'd1,
        ST_WAIT_IDLE = 2'd2,
        ST_DONE      = 2'd3
    } arb_state_t;

    localparam int GO_BIT   = 31;
    localparam int IDLE_BIT = 0;

    // Low (nbytes+1)*8 bits set; only the received bytes survive the mask.
    function automatic logic [31:0] bytes_to_mask(input logic [1:0] nbytes);
        logic [31:0] mask;
        case (nbytes)
            2'd0:    mask = 32'h0000_00FF;
            2'd1:    mask = 32'h0000_FFFF;
            2'd2:    mask = 32'h00FF_FFFF;
            2'd3:    mask = 32'hFFFF_FFFF;
            default: mask = 32'hFFFF_FFFF;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/spi_arb_rr.sv
// Grant selection for the SPI arbiter. Searches the request vector starting
// one past the last owner; with fixed_prio set the search always starts at
// index 0, which gives lowest-index-wins priority from the same loop.
module spi_arb_rr
    import spi_arb_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0] req,
    input  logic [2:0]      last,
    input  logic            fixed_prio,
    output logic [NREQ-1:0] grant,
    output logic [2:0]      grant_idx,
    output logic            any
);

    // Pick the first requester found after the starting point, wrapping once.
    always_comb begin
        int start_s;
        int pos_s;
        grant     = {NREQ{1'b0}};
        grant_idx = 3'd0;
        any       = 1'b0;
        if (fixed_prio) begin
            start_s = NREQ - 1;
        end else begin
            start_s = int'(last);
        end
        for (int k = 1; k <= NREQ; k++) begin
            pos_s = (start_s + k) % NREQ;
            if (!any && req[pos_s]) begin
                any          = 1'b1;
                grant[pos_s] = 1'b1;
                grant_idx    = 3'(pos_s);
            end else begin
                any = any;
            end
        end
    end

endmodule

// File: rtl/spi_arbiter.sv
// Shares one register-level SPI engine between NREQ requesters.
// Build option: define SPI_ARB_FIXED_PRIO_EN for fixed lowest-index-first
// priority; otherwise grants rotate round-robin.
module spi_arbiter
    import spi_arb_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int WAIT_MAX = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [2*NREQ-1:0]    req_nbytes,
    input  logic [32*NREQ-1:0]   req_wdata,
    output logic [NREQ-1:0]      req_ready,
    output logic [NREQ-1:0]      rsp_valid,
    output logic [31:0]          rsp_rdata,
    output logic                 rsp_err,
    output logic                 busy,
    output logic [2:0]           grant_id,
    output logic [31:0]          spi_control,
    output logic [31:0]          spi_wrdata,
    input  logic [31:0]          spi_rddata,
    input  logic [31:0]          spi_status
);

    localparam int CW = $clog2(WAIT_MAX + 1);

`ifdef SPI_ARB_FIXED_PRIO_EN
    localparam logic FIXED_PRIO = 1'b1;
`else
    localparam logic FIXED_PRIO = 1'b0;
`endif

    arb_state_t         state_r;
    logic [2:0]         last_r;
    logic [1:0]         nbytes_r;
    logic [CW-1:0]      cnt_r;
    logic [CW-1:0]      cnt_next_s;
    logic               err_r;
    logic [31:0]        data_r;

    logic [NREQ-1:0]    grant_s;
    logic [2:0]         grant_idx_s;
    logic               any_s;
    logic [31:0]        sel_wdata_s;
    logic [1:0]         sel_nbytes_s;
    logic [NREQ-1:0]    owner_onehot_s;
    logic               unused_status_s;

    // Only the idle flag of the engine status word is consumed.
    assign unused_status_s = ^spi_status[31:1];

    spi_arb_rr #(.NREQ(NREQ)) u_rr (
        .req        (req_valid),
        .last       (last_r),
        .fixed_prio (FIXED_PRIO),
        .grant      (grant_s),
        .grant_idx  (grant_idx_s),
        .any        (any_s)
    );

    assign cnt_next_s = cnt_r + CW'(1);

    // Acceptance is only possible in IDLE and never while reset is asserted.
    always_comb begin
        if (!reset && (state_r == ST_IDLE) && any_s) begin
            req_ready = grant_s;
        end else begin
            req_ready = {NREQ{1'b0}};
        end
    end

    // Route the winning requester's write word and byte count.
    always_comb begin
        sel_wdata_s  = req_wdata[32*int'(grant_idx_s) +: 32];
        sel_nbytes_s = req_nbytes[2*int'(grant_idx_s) +: 2];
    end

    // One-hot view of the latched owner for the response pulse.
    always_comb begin
        owner_onehot_s = {NREQ{1'b0}};
        for (int i = 0; i < NREQ; i++) begin
            owner_onehot_s[i] = (grant_id == 3'(i));
        end
    end

    // Transfer FSM: launch, wait for engine start, wait for completion, respond.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            last_r      <= 3'(NREQ - 1);
            nbytes_r    <= 2'd0;
            cnt_r       <= {CW{1'b0}};
            err_r       <= 1'b0;
            data_r      <= 32'h0;
            rsp_valid   <= {NREQ{1'b0}};
            rsp_rdata   <= 32'h0;
            rsp_err     <= 1'b0;
            busy        <= 1'b0;
            grant_id    <= 3'd0;
            spi_control <= 32'h0;
            spi_wrdata  <= 32'h0;
        end else begin
            rsp_valid <= {NREQ{1'b0}};
            rsp_rdata <= 32'h0;
            rsp_err   <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (any_s) begin
                        spi_wrdata  <= sel_wdata_s;
                        spi_control <= {1'b1, 29'b0, sel_nbytes_s};
                        grant_id    <= grant_idx_s;
                        last_r      <= grant_idx_s;
                        nbytes_r    <= sel_nbytes_s;
                        cnt_r       <= {CW{1'b0}};
                        err_r       <= 1'b0;
                        data_r      <= 32'h0;
                        busy        <= 1'b1;
                        state_r     <= ST_WAIT_BUSY;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                ST_WAIT_BUSY: begin
                    cnt_r <= cnt_next_s;
                    if (!spi_status[IDLE_BIT]) begin
                        spi_control[GO_BIT] <= 1'b0;
                        state_r             <= ST_WAIT_IDLE;
                    end else if (cnt_next_s == CW'(WAIT_MAX)) begin
                        spi_control[GO_BIT] <= 1'b0;
                        err_r               <= 1'b1;
                        state_r             <= ST_DONE;
                    end else begin
                        state_r <= ST_WAIT_BUSY;
                    end
                end
                ST_WAIT_IDLE: begin
                    if (spi_status[IDLE_BIT]) begin
                        data_r  <= spi_rddata & bytes_to_mask(nbytes_r);
                        state_r <= ST_DONE;
                    end else begin
                        state_r <= ST_WAIT_IDLE;
                    end
                end
                ST_DONE: begin
                    rsp_valid <= owner_onehot_s;
                    rsp_rdata <= data_r;
                    rsp_err   <= err_r;
                    err_r     <= 1'b0;
                    busy      <= 1'b0;
                    state_r   <= ST_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_arbiter.sv
// Scoreboard bench for spi_arbiter with a small behavioural SPI engine model.
`timescale 1ns/1ps
module tb_spi_arbiter;

    localparam int NREQ     = 4;
    localparam int WAIT_MAX = 16;
    localparam int LAT      = 8;   // accept -> rsp_valid with the engine model below

    logic                clk = 1'b0;
    logic                reset;
    logic [NREQ-1:0]     req_valid;
    logic [2*NREQ-1:0]   req_nbytes;
    logic [32*NREQ-1:0]  req_wdata;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ-1:0]     rsp_valid;
    logic [31:0]         rsp_rdata;
    logic                rsp_err;
    logic                busy;
    logic [2:0]          grant_id;
    logic [31:0]         spi_control;
    logic [31:0]         spi_wrdata;
    logic [31:0]         spi_rddata;
    logic [31:0]         spi_status;

    always #5 clk = ~clk;

    spi_arbiter #(.NREQ(NREQ), .WAIT_MAX(WAIT_MAX)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_nbytes(req_nbytes), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .busy(busy), .grant_id(grant_id),
        .spi_control(spi_control), .spi_wrdata(spi_wrdata),
        .spi_rddata(spi_rddata), .spi_status(spi_status)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int go_viol = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- engine model ----------------
    logic        eng_idle;
    logic        go_prev;
    logic        stuck = 1'b0;
    int          eng_cnt;
    logic [31:0] model_rdata = 32'h0;
    logic [31:0] eng_rddata;
    logic [31:0] eng_wdata = 32'h0;
    logic [1:0]  eng_nb = 2'd0;
    int          go_edges = 0;

    assign spi_status = {31'h0, eng_idle};
    assign spi_rddata = eng_rddata;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            eng_idle   <= 1'b1;
            go_prev    <= 1'b0;
            eng_cnt    <= 0;
            eng_rddata <= 32'h0;
        end else begin
            go_prev <= spi_control[31];
            if (spi_control[31] && !go_prev) begin
                go_edges  <= go_edges + 1;
                eng_wdata <= spi_wrdata;
                eng_nb    <= spi_control[1:0];
            end
            if (eng_idle) begin
                if (spi_control[31] && !go_prev && !stuck) begin
                    eng_idle <= 1'b0;
                    eng_cnt  <= 3;
                end
            end else if (eng_cnt == 0) begin
                eng_idle   <= 1'b1;
                eng_rddata <= model_rdata;
            end else begin
                eng_cnt <= eng_cnt - 1;
            end
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        int          idx;
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t        exp_q[$];
    int          grant_log[$];
    logic [31:0] tbl [NREQ];
    logic        no_push = 1'b0;
    int          acc_cnt = 0;

    // Acceptance monitor: pushes the hand-set expected response for the winner.
    always @(negedge clk) begin : acc_mon
        int   idx;
        exp_t e;
        if (!reset && ((req_valid & req_ready) != '0)) begin
            idx = 0;
            for (int i = 0; i < NREQ; i++) if (req_valid[i] & req_ready[i]) idx = i;
            check("req_ready_onehot", 32'($onehot(req_ready)), 32'd1);
            acc_cnt++;
            grant_log.push_back(idx);
            if (!no_push) begin
                e.idx   = idx;
                e.rdata = stuck ? 32'h0 : tbl[idx];
                e.err   = stuck;
                e.cyc   = cyc + (stuck ? WAIT_MAX + 2 : LAT);
                exp_q.push_back(e);
            end
        end
    end

    // Response monitor: pops and compares whenever the DUT pulses rsp_valid.
    always @(negedge clk) begin : rsp_mon
        exp_t e;
        if (rsp_valid != '0) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_rsp: rsp_valid=%b with empty scoreboard", rsp_valid);
            end else begin
                e = exp_q.pop_front();
                check("rsp_valid", 32'(rsp_valid), 32'd1 << e.idx);
                check("rsp_rdata", rsp_rdata, e.rdata);
                check("rsp_err", 32'(rsp_err), 32'(e.err));
                check("rsp_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
        if (spi_control[31] && !busy) go_viol++;
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_accepts(input int target);
        int n = 0;
        while (acc_cnt < target && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("accept_in_time", 32'(acc_cnt >= target), 32'd1);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic do_req(input int i, input logic [1:0] nb, input logic [31:0] wd);
        int base;
        base = acc_cnt;
        req_nbytes[2*i +: 2]  = nb;
        req_wdata[32*i +: 32] = wd;
        req_valid[i]          = 1'b1;
        wait_accepts(base + 1);
        req_valid[i] = 1'b0;
    endtask

`ifdef SPI_ARB_FIXED_PRIO_EN
    int exp_order[5] = '{0, 0, 0, 0, 0};
`else
    int exp_order[5] = '{0, 1, 2, 3, 0};
`endif

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int base;
        int edges0;
        reset      = 1'b1;
        req_valid  = 4'hF;
        req_nbytes = '0;
        req_wdata  = '0;
        for (int i = 0; i < NREQ; i++) tbl[i] = 32'h0;
        repeat (3) @(negedge clk);

        // Reset state, with requests pending to show req_ready is held low.
        check("reset_req_ready", 32'(req_ready), 32'h0);
        check("reset_spi_control", spi_control, 32'h0);
        check("reset_spi_wrdata", spi_wrdata, 32'h0);
        check("reset_busy", 32'(busy), 32'h0);
        check("reset_rsp_valid", 32'(rsp_valid), 32'h0);
        check("reset_grant_id", 32'(grant_id), 32'h0);
        req_valid = 4'h0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Fairness: all four held for five grants; nbytes = index.
        model_rdata = 32'h1234_5678;
        tbl[0] = 32'h0000_0078; tbl[1] = 32'h0000_5678;
        tbl[2] = 32'h0034_5678; tbl[3] = 32'h1234_5678;
`ifdef SPI_ARB_FIXED_PRIO_EN
        tbl[1] = 32'h0000_0078; tbl[2] = 32'h0000_0078; tbl[3] = 32'h0000_0078;
`endif
        for (int i = 0; i < NREQ; i++) begin
            req_nbytes[2*i +: 2]  = 2'(i);
            req_wdata[32*i +: 32] = 32'h1000_0000 + 32'(i);
        end
        edges0 = go_edges;
        base   = acc_cnt;
        req_valid = 4'hF;
        wait_accepts(base + 5);
        req_valid = 4'h0;
        wait_drain();
        for (int k = 0; k < 5; k++) check("grant_order", 32'(grant_log[base + k]), 32'(exp_order[k]));
        check("go_edges", 32'(go_edges - edges0), 32'd5);

        // Single request: 2 bytes, junk above the mask must be dropped.
        model_rdata = 32'h12C3_3C00;
        tbl[0] = 32'h0000_3C00;
        do_req(0, 2'd1, 32'h0000_A55A);
        wait_drain();
        check("engine_wdata", eng_wdata, 32'h0000_A55A);
        check("engine_nbytes", 32'(eng_nb), 32'd1);

        // Stuck engine: error response, go dropped, then a normal transfer.
        stuck = 1'b1;
        do_req(2, 2'd0, 32'h0000_0055);
        wait_drain();
        check("stuck_go_low", 32'(spi_control[31]), 32'd0);
        stuck = 1'b0;
        model_rdata = 32'hFFAB_CDEF;
        tbl[1] = 32'h00AB_CDEF;
        do_req(1, 2'd2, 32'h0011_2233);
        wait_drain();

        // Full word.
        model_rdata = 32'hDEAD_BEEF;
        tbl[3] = 32'hDEAD_BEEF;
        do_req(3, 2'd3, 32'hCAFE_F00D);
        wait_drain();

        // Reset while waiting for the engine to finish.
        no_push = 1'b1;
        do_req(2, 2'd1, 32'h0000_7777);
        repeat (2) @(negedge clk);
        check("pre_reset_busy", 32'(busy), 32'd1);
        check("pre_reset_go_low", 32'(spi_control[31]), 32'd0);
        reset = 1'b1;
        #1;
        check("abort_spi_control", spi_control, 32'h0);
        check("abort_busy", 32'(busy), 32'h0);
        check("abort_rsp_valid", 32'(rsp_valid), 32'h0);
        check("abort_grant_id", 32'(grant_id), 32'h0);
        repeat (2) @(negedge clk);
        reset   = 1'b0;
        no_push = 1'b0;
        model_rdata = 32'h0BAD_F00D;
        tbl[0] = 32'h0000_000D;
        tbl[3] = 32'h0BAD_F00D;
        req_nbytes[1:0] = 2'd0;
        req_nbytes[7:6] = 2'd3;
        base = acc_cnt;
        req_valid = 4'b1001;
        #1;
        check("post_reset_first_grant", 32'(req_ready), 32'h1);
        wait_accepts(base + 1);
        req_valid[0] = 1'b0;
        wait_accepts(base + 2);
        req_valid[3] = 1'b0;
        wait_drain();
        check("post_reset_order0", 32'(grant_log[base]), 32'd0);
        check("post_reset_order1", 32'(grant_log[base + 1]), 32'd3);

        repeat (4) @(negedge clk);
        check("go_only_while_busy", 32'(go_viol), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_arbiter.md
# spi_arbiter

Shares one `spi_top` register-level SPI engine between `NREQ` requesters. The block arbitrates pending transfer requests (round-robin by default), drives the engine's `control`/`wrdata` inputs, and watches `status[0]` to detect completion. It returns the masked read word to the winning requester with a one-cycle response pulse. It sits between firmware/datapath clients and the single `spi_top` instance.

## Interface
- `NREQ`, 4: number of requesters, 2..8
- `WAIT_MAX`, 16: max cycles to wait for the engine to leave idle after `go` before flagging an error
- `clk` in 1: system clock
- `reset` in 1: asynchronous, active-high reset
- `req_valid` in NREQ: request pending, one bit per requester; held until accepted
- `req_nbytes` in 2*NREQ: per requester, bytes-minus-one (0..3) in slice `[2*i+:2]`
- `req_wdata` in 32*NREQ: per requester, write word in slice `[32*i+:32]`; the top byte of the selected range is sent first
- `req_ready` out NREQ: one-hot acceptance; a transfer is taken when `req_valid[i] & req_ready[i]`
- `rsp_valid` out NREQ: one-hot, one-cycle completion pulse to the owner
- `rsp_rdata` out 32: read data, valid with `rsp_valid`
- `rsp_err` out 1: engine did not start within `WAIT_MAX`; valid with `rsp_valid`
- `busy` out 1: high in any state other than IDLE
- `grant_id` out 3: index of the current or last owner
- `spi_control` out 32: to engine `control`; bit31 = go, [1:0] = num_bytes, rest 0
- `spi_wrdata` out 32: to engine `wrdata`
- `spi_rddata` in 32: from engine `rddata`
- `spi_status` in 32: from engine `status`; bit0 = engine idle

## Operation
- States: IDLE, WAIT_BUSY, WAIT_IDLE, DONE.
- **IDLE:**
  - Combinational grant over `req_valid`.
  - `req_ready` is the one-hot grant when at least one request is valid; otherwise 0.
  - On acceptance:
    - register `spi_wrdata` ← slice, `spi_control` ← {1'b1, 29'b0, nbytes}
    - latch `grant_id`, nbytes
    - clear the timeout counter
    - go to WAIT_BUSY
- **WAIT_BUSY:**
  - Go is held high and the counter increments.
  - If `spi_status[0]==0`: clear go, go to WAIT_IDLE.
  - Else, if the counter reaches `WAIT_MAX`: clear go, set the err flag, go to DONE.
- **WAIT_IDLE:**
  - Go is low.
  - When `spi_status[0]==1`: capture `spi_rddata & mask`, go to DONE.
  - Mask is the low (nbytes+1)*8 bits set. Examples: nbytes=0 → 0x000000FF; nbytes=3 → 0xFFFFFFFF.
- **DONE:**
  - For one cycle: `rsp_valid[grant_id]`=1, `rsp_rdata` = captured word, `rsp_err` = flag.
  - Then go to IDLE and clear the flag.
- **Round-robin:**
  - Search starts at `last+1` mod NREQ.
  - `last` updates on acceptance.
  - Reset value of `last` = NREQ-1, so requester 0 wins first.
- Go is never high in IDLE. This guarantees at least one low cycle between transfers, which the engine's rising-edge detect requires.
- Requests arriving while busy wait. `req_ready` is 0 outside IDLE.
- **Reset (any state, including mid-transfer):** immediately forces:
  - all outputs 0
  - `grant_id`=0
  - state IDLE
  - `last`=NREQ-1
- The engine is reset separately. No response is issued for an aborted transfer.

## Timing
- **Cycle T:** accept; `req_ready` is combinational in T.
- **Cycle T+1:** `spi_control[31]`=1.
- **Cycle T+2:** engine deasserts `status[0]`.
- **Cycle T+3:** state WAIT_IDLE, go low.
- **Response:** `rsp_valid` one cycle after the DONE transition, i.e. 2 cycles after `status[0]` returns high.
- **Back-to-back:** next accept no earlier than the IDLE cycle after DONE.
- **Error path:** `rsp_valid` with `rsp_err`=1 arrives WAIT_MAX+2 cycles after accept.
- Outputs are registered except `req_ready`.

## Configuration
- `SPI_ARB_FIXED_PRIO_EN`
  - **Defined:** fixed priority; lowest index wins; `last` pointer is unused.
  - **Undefined (default):** round-robin as above.

## Structure
- Shared package `spi_arb_pkg`:
  - state encoding constants (IDLE=0, WAIT_BUSY=1, WAIT_IDLE=2, DONE=3)
  - `GO_BIT`=31
  - `IDLE_BIT`=0
  - bytes-to-mask function
- Sub-module `spi_arb_rr`: parameterised NREQ grant logic (request vector, last pointer, fixed-prio select → one-hot grant + index).
- The top contains the FSM, counter and registers.

## Test plan
- **Single request:** req0, nbytes=1, wdata=0x0000A55A; model returns rddata 0x00C3_3C00 | junk 0x12000000 → `rsp_valid[0]` with `rsp_rdata`=0x00003C00 masked to 0x0000FFFF, i.e. 0x3C00; `rsp_err`=0.
- **Round-robin fairness:** req0..3 held continuously → grant order 0,1,2,3,0; a new `go` edge for each, with go low ≥1 cycle between.
- **Fixed priority** (`SPI_ARB_FIXED_PRIO_EN`): req0 and req2 held → req0 is served every time; req2 starves.
- **Stuck engine:** `spi_status[0]` held 1 → `rsp_err`=1 at accept+WAIT_MAX+2; go deasserted; next request is accepted normally.
- **Reset mid-transfer:** assert `reset` in WAIT_IDLE → `spi_control`=0, `busy`=0 and `rsp_valid`=0 immediately; the first grant after release goes to req0.
- **nbytes=3:** `spi_rddata`=0xDEADBEEF → `rsp_rdata`=0xDEADBEEF.
